preview_fifo_n: RTL
===================

PREVIEW_FIFO_N -- requirements
Module: preview_fifo_n

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits (>=1).
REQ-002 SHALL have parameter LANES, default 4, max words written or read per cycle (>=2).
REQ-003 SHALL have parameter DEPTH, default 16, storage words (power of 2, >=2*LANES).
REQ-004 SHALL have derived parameters CNT_W = $clog2(LANES+1) and USED_W = $clog2(DEPTH)+1.
REQ-005 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port nrst  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port wr_cnt  input  CNT_W  number of words to write this cycle (0..LANES).
REQ-008 SHALL have port id  input  LANES*WIDTH  write words; lane 0 (bits WIDTH-1:0) is oldest.
REQ-009 SHALL have port rd_cnt  input  CNT_W  number of words to pop this cycle (0..LANES).
REQ-010 SHALL have port od  output  LANES*WIDTH  preview of the oldest LANES stored words; lane 0 is the head.
REQ-011 SHALL have port od_valid  output  LANES  bit i high when lane i of od holds a stored word.
REQ-012 SHALL have port usedw  output  USED_W  stored word count (0..DEPTH).
REQ-013 SHALL have port freew  output  USED_W  free slot count, always DEPTH-usedw.
REQ-014 SHALL have ports empty, full  output  1 each  usedw==0, usedw==DEPTH.
REQ-015 SHALL have ports wr_ovf, rd_unf  output  1 each  one-cycle reject pulses.

Function
REQ-016 SHALL store words in an internal DEPTH-entry circular array with head and tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH; no vendor FIFO primitives.
REQ-017 SHALL accept a write when wr_cnt<=LANES and wr_cnt<=freew (pre-edge value), storing id lanes 0..wr_cnt-1 at tail..tail+wr_cnt-1 in order, and advancing tail by wr_cnt.
REQ-018 SHALL accept a read when rd_cnt<=LANES and rd_cnt<=usedw (pre-edge value), advancing head by rd_cnt.
REQ-019 SHALL reject requests all-or-nothing: rejected write stores nothing, rejected read pops nothing; partial transfers never occur.
REQ-020 SHALL assert wr_ovf for exactly the cycle after a rejected nonzero or out-of-range wr_cnt; likewise rd_unf for rd_cnt.
REQ-021 SHALL evaluate write and read acceptance independently against pre-edge usedw; same-cycle read does not free space for same-cycle write, same-cycle write cannot satisfy same-cycle read.
REQ-022 SHALL update usedw as usedw + accepted_wr - accepted_rd every cycle; a simultaneous accepted read and write of equal count leaves usedw unchanged.
REQ-023 SHALL drive od lane i combinationally from array[head+i mod DEPTH]; od_valid[i] = (usedw > i); od lanes with od_valid low are don't-care.
REQ-024 SHALL make a written word visible on od one cycle after the write edge (show-ahead, latency 1); a popped word disappears from od at the same edge.
REQ-025 SHALL treat wr_cnt==0 / rd_cnt==0 as idle with no flag activity.
REQ-026 SHALL keep pointers, usedw and stored data coherent across pointer wrap-around at any lane offset.

Reset
REQ-027 SHALL, while nrst is low at a rising edge, set head=0, tail=0, usedw=0, wr_ovf=0, rd_unf=0, ignoring wr_cnt/rd_cnt that cycle.
REQ-028 SHALL present after reset: empty=1, full=0, freew=DEPTH, od_valid=0; array contents need not be cleared.
REQ-029 SHALL discard all stored words on reset asserted mid-operation; first post-reset read sees only post-reset writes.

Verification (WIDTH=8, LANES=4, DEPTH=16)
REQ-030 SHALL verify: reset, then wr_cnt=3 id={..,0x03,0x02,0x01} -> next cycle usedw=3, od lanes0..2=0x01,0x02,0x03, od_valid=4'b0111.
REQ-031 SHALL verify: with usedw=3, rd_cnt=2 -> next cycle usedw=1, od lane0=0x03, od_valid=4'b0001; then rd_cnt=2 -> rd_unf pulse, usedw stays 1.
REQ-032 SHALL verify: fill to usedw=14, wr_cnt=3 -> wr_ovf pulse, usedw 14; wr_cnt=2 -> usedw=16, full=1, freew=0.
REQ-033 SHALL verify: usedw=16 with simultaneous rd_cnt=4, wr_cnt=4 -> read accepted, write rejected (wr_ovf=1), usedw=12.
REQ-034 SHALL verify wrap: 40 cycles of wr_cnt=3 / rd_cnt=3 with incrementing data -> od sequence strictly incrementing, usedw constant, no flags.
REQ-035 SHALL verify: nrst low one cycle with usedw=9 -> next cycle usedw=0, empty=1, od_valid=0, flags low.

Source files
------------

// File: rtl/preview_fifo_n.sv
// Multi-lane show-ahead FIFO. Each cycle it accepts 0..LANES words in and pops 0..LANES words out.
// The oldest LANES stored words are always previewed on od.
module preview_fifo_n #(
  parameter int WIDTH  = 32,
  parameter int LANES  = 4,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(LANES + 1),
  parameter int USED_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [CNT_W-1:0]       wr_cnt,
  input  logic [LANES*WIDTH-1:0] id,
  input  logic [CNT_W-1:0]       rd_cnt,
  output logic [LANES*WIDTH-1:0] od,
  output logic [LANES-1:0]       od_valid,
  output logic [USED_W-1:0]      usedw,
  output logic [USED_W-1:0]      freew,
  output logic                   empty,
  output logic                   full,
  output logic                   wr_ovf,
  output logic                   rd_unf
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [USED_W-1:0] used_q, used_d;
  logic              wr_ovf_q, wr_ovf_d;
  logic              rd_unf_q, rd_unf_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];

  logic              wr_acc, rd_acc;
  logic [USED_W-1:0] wr_add, rd_sub;
  logic [USED_W-1:0] free_w;

  assign free_w = USED_W'(DEPTH) - used_q;

  // Both sides are judged against the pre-edge fill level, so a same-cycle
  // read never makes room for a same-cycle write and vice versa.
  always_comb begin
    wr_acc   = (wr_cnt != '0) && (wr_cnt <= CNT_W'(LANES)) && (USED_W'(wr_cnt) <= free_w);
    rd_acc   = (rd_cnt != '0) && (rd_cnt <= CNT_W'(LANES)) && (USED_W'(rd_cnt) <= used_q);
    wr_ovf_d = (wr_cnt != '0) && !wr_acc;
    rd_unf_d = (rd_cnt != '0) && !rd_acc;
    wr_add   = wr_acc ? USED_W'(wr_cnt) : '0;
    rd_sub   = rd_acc ? USED_W'(rd_cnt) : '0;
    used_d   = used_q + wr_add - rd_sub;
    tail_d   = tail_q + (wr_acc ? PTR_W'(wr_cnt) : '0);
    head_d   = head_q + (rd_acc ? PTR_W'(rd_cnt) : '0);
  end

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < LANES; i++) begin
      if (wr_acc && (CNT_W'(i) < wr_cnt)) begin
        mem_d[tail_q + PTR_W'(i)] = id[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      head_q   <= '0;
      tail_q   <= '0;
      used_q   <= '0;
      wr_ovf_q <= 1'b0;
      rd_unf_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      used_q   <= used_d;
      wr_ovf_q <= wr_ovf_d;
      rd_unf_q <= rd_unf_d;
    end
  end

  // Storage is not reset; the pointers alone define which words are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    od       = '0;
    od_valid = '0;
    for (int i = 0; i < LANES; i++) begin
      od[i*WIDTH +: WIDTH] = mem_q[head_q + PTR_W'(i)];
      od_valid[i]          = used_q > USED_W'(i);
    end
  end

  assign usedw  = used_q;
  assign freew  = free_w;
  assign empty  = (used_q == '0);
  assign full   = (used_q == USED_W'(DEPTH));
  assign wr_ovf = wr_ovf_q;
  assign rd_unf = rd_unf_q;

endmodule
